traceback_unit: RTL and testbench

- Viterbi traceback stage, directly downstream of the survivor-path memory.
- Consumes one full survivor vector per enabled cycle (previous-state pointer for every state), delivered newest-first in reverse trellis order.
- Walks the pointer chain from a start state and recovers one decoded bit per step.
- Reverses the recovered bits through an internal LIFO and emits them in forward (chronological) order.

---
 rtl/traceback_unit_pkg.sv | 23 ++
 rtl/traceback_unit_lifo.sv | 24 ++
 rtl/traceback_unit.sv | 119 +++++++++++
 tb/tb_traceback_unit.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/traceback_unit_pkg.sv
// Shared constants and types for the Viterbi traceback stage.
// The trellis geometry and traceback depth are fixed here for the whole decoder.
package traceback_unit_pkg;

    localparam int STATE_W   = 8;
    localparam int STATE_NUM = 2 ** STATE_W;
    localparam int TB_DEPTH  = 64;
    localparam int CNT_W     = 7;
    localparam int LIFO_AW   = $clog2(TB_DEPTH);

    typedef logic [STATE_W-1:0] state_t;
    typedef logic [CNT_W-1:0]   cnt_t;
    typedef logic [LIFO_AW-1:0] lifo_idx_t;

    typedef enum logic [1:0] {
        IDLE,
        TRACE,
        EMIT
    } tb_fsm_t;

    localparam cnt_t CNT_LAST = cnt_t'(TB_DEPTH - 1);

endpackage

// File: rtl/traceback_unit_lifo.sv
// Bit stack that reverses the traceback order.
// Pushes are addressed by the trace step and pops by the mirrored emit step.
module tb_lifo
    import traceback_unit_pkg::*;
(
    input  logic               clk,
    input  logic               we,
    input  logic [LIFO_AW-1:0] wr_idx,
    input  logic               wr_bit,
    input  logic [LIFO_AW-1:0] rd_idx,
    output logic               rd_bit
);

    logic [TB_DEPTH-1:0] mem;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_idx] <= wr_bit;
        end
    end

    assign rd_bit = mem[rd_idx];

endmodule

// File: rtl/traceback_unit.sv
// Viterbi traceback: follows survivor pointers from a start state, stacks one
// decoded bit per step, then replays the stack in chronological order.
module traceback_unit
    import traceback_unit_pkg::*;
(
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              en_t,
    input  logic                              i_sync,
    input  logic [STATE_W-1:0]                i_start_st,
    input  logic [STATE_NUM-1:0][STATE_W-1:0] i_bck_prv_st,
    output logic                              o_bit,
    output logic                              o_valid,
    output logic                              o_done,
    output logic                              o_busy
);

    tb_fsm_t   fsm_q;
    tb_fsm_t   fsm_d;
    state_t    cur_st_q;
    state_t    cur_st_d;
    cnt_t      cnt_q;
    cnt_t      cnt_d;
    logic      sync_q;
    logic      start;
    logic      lifo_we;
    logic      emit_fire;
    logic      emit_last;
    logic      rd_bit;
    lifo_idx_t wr_idx;
    lifo_idx_t rd_idx;

    assign start  = en_t & i_sync & ~sync_q & (fsm_q == IDLE);
    assign o_busy = (fsm_q != IDLE);
    assign wr_idx = lifo_idx_t'(cnt_q);
    assign rd_idx = lifo_idx_t'(CNT_LAST - cnt_q);

    // cur_st is loaded with the start state, so the first trace step indexes
    // the survivor vector with exactly the sampled start state.
    always_comb begin
        fsm_d     = fsm_q;
        cur_st_d  = cur_st_q;
        cnt_d     = cnt_q;
        lifo_we   = 1'b0;
        emit_fire = 1'b0;
        emit_last = 1'b0;
        unique case (fsm_q)
            IDLE: begin
                if (start) begin
                    fsm_d    = TRACE;
                    cur_st_d = i_start_st;
                    cnt_d    = '0;
                end
            end
            TRACE: begin
                if (en_t) begin
                    lifo_we  = 1'b1;
                    cur_st_d = i_bck_prv_st[cur_st_q];
                    if (cnt_q == CNT_LAST) begin
                        fsm_d = EMIT;
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            EMIT: begin
                if (en_t) begin
                    emit_fire = 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        emit_last = 1'b1;
                        fsm_d     = IDLE;
                        cnt_d     = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                fsm_d = IDLE;
                cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            fsm_q    <= IDLE;
            cur_st_q <= '0;
            cnt_q    <= '0;
            sync_q   <= 1'b0;
            o_bit    <= 1'b0;
            o_valid  <= 1'b0;
            o_done   <= 1'b0;
        end else begin
            fsm_q    <= fsm_d;
            cur_st_q <= cur_st_d;
            cnt_q    <= cnt_d;
            if (en_t) begin
                sync_q <= i_sync;
            end
            o_valid <= emit_fire;
            o_done  <= emit_fire & emit_last;
            if (emit_fire) begin
                o_bit <= rd_bit;
            end
        end
    end

    tb_lifo u_lifo (
        .clk    (clk),
        .we     (lifo_we),
        .wr_idx (wr_idx),
        .wr_bit (cur_st_q[STATE_W-1]),
        .rd_idx (rd_idx),
        .rd_bit (rd_bit)
    );

endmodule

// File: tb/tb_traceback_unit.sv
// Randomised self-checking bench for traceback_unit against a pointer-chain model.
module tb_traceback_unit;
    import traceback_unit_pkg::*;

    localparam int M_ID    = 0;
    localparam int M_SHIFT = 1;
    localparam int M_RAND  = 2;
    localparam int M_START = 3;

    logic clk = 1'b0;
    logic rst;
    logic en_t;
    logic i_sync;
    logic [STATE_W-1:0] i_start_st;
    logic [STATE_NUM-1:0][STATE_W-1:0] prv;
    logic o_bit;
    logic o_valid;
    logic o_done;
    logic o_busy;

    traceback_unit dut (
        .clk          (clk),
        .rst          (rst),
        .en_t         (en_t),
        .i_sync       (i_sync),
        .i_start_st   (i_start_st),
        .i_bck_prv_st (prv),
        .o_bit        (o_bit),
        .o_valid      (o_valid),
        .o_done       (o_done),
        .o_busy       (o_busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n_valid = 0;
    int n_done = 0;
    int exp_valid = 0;
    int exp_done = 0;
    logic start_flag;
    logic [63:0] pat;
    logic exp_q[$];
    state_t vecs [TB_DEPTH][STATE_NUM];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Survivor vectors for each step of one block.
    task automatic build_vecs(input int mode);
        for (int k = 0; k < TB_DEPTH; k++) begin
            for (int s = 0; s < STATE_NUM; s++) begin
                state_t sv;
                logic   nb;
                sv = state_t'(s);
                nb = (k + 8 < 64) ? pat[k+8] : 1'b0;
                case (mode)
                    M_ID:    vecs[k][s] = sv;
                    M_SHIFT: vecs[k][s] = {sv[STATE_W-2:0], nb};
                    default: vecs[k][s] = state_t'($urandom);
                endcase
            end
        end
        if (mode == M_START) vecs[0][8'h3C] = 8'hA5;
    endtask

    // Walk the chain backwards in time, then reverse: emit[i] is the i-th output bit.
    task automatic model(input state_t s0, output logic [TB_DEPTH-1:0] emit);
        state_t st;
        logic [TB_DEPTH-1:0] rec;
        st = s0;
        for (int k = 0; k < TB_DEPTH; k++) begin
            rec[k] = st[STATE_W-1];
            st = vecs[k][st];
        end
        for (int i = 0; i < TB_DEPTH; i++) emit[i] = rec[TB_DEPTH-1-i];
    endtask

    task automatic drive_vec(input int k);
        for (int s = 0; s < STATE_NUM; s++)
            prv[s] = (k < 0) ? state_t'($urandom) : vecs[k][s];
    endtask

    task automatic do_abort();
        rst = 1'b0; en_t = 1'b0; drive_vec(-1);
        @(negedge clk);
        rst = 1'b1; en_t = 1'b1; i_sync = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_flush", 64'(exp_q.size()), 64'd0);
    endtask

    function automatic state_t shift_s0();
        state_t s;
        for (int i = 0; i < 8; i++) s[7-i] = pat[i];
        return s;
    endfunction

    // abort_at: -1 none, 0..63 reset at that trace step, 64+n reset at emit bit n.
    task automatic run_block(input int mode, input state_t s0, input int off_pct,
                             input int abort_at, input bit toggle, input int hold);
        logic [TB_DEPTH-1:0] emit;
        logic [63:0] lit;
        int k;
        int e;
        build_vecs(mode);
        model(s0, emit);
        case (mode)
            M_ID: chk("model_identity", 64'(emit), 64'hFFFF_FFFF_FFFF_FFFF);
            M_SHIFT: begin
                for (int i = 0; i < 64; i++) lit[i] = pat[63-i];
                chk("model_shift", 64'(emit), lit);
            end
            M_START: begin
                chk("model_start_push0", 64'(emit[TB_DEPTH-1]), 64'd0);
                chk("model_start_push1", 64'(emit[TB_DEPTH-2]), 64'd1);
            end
            default: ;
        endcase
        chk("leftover_bits", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        for (int i = 0; i < TB_DEPTH; i++) exp_q.push_back(emit[i]);

        @(negedge clk);
        en_t = 1'b1; i_sync = 1'b1; i_start_st = s0; drive_vec(0); start_flag = 1'b1;
        k = 0;
        while (k < TB_DEPTH) begin
            @(negedge clk);
            start_flag = 1'b0;
            i_start_st = state_t'($urandom);
            if (abort_at == k) begin
                do_abort();
                return;
            end
            i_sync = !(toggle && k == 30);
            en_t = ($urandom_range(0, 99) >= off_pct);
            if (en_t) begin
                drive_vec(k);
                k++;
            end else begin
                drive_vec(-1);
            end
        end
        e = 0;
        while (e < TB_DEPTH) begin
            @(negedge clk);
            i_sync = 1'b1;
            if (abort_at == TB_DEPTH + e) begin
                exp_valid += e;
                do_abort();
                return;
            end
            en_t = ($urandom_range(0, 99) >= off_pct);
            drive_vec(-1);
            if (en_t) e++;
        end
        exp_valid += TB_DEPTH;
        exp_done++;
        for (int c = 0; c < hold + 3; c++) begin
            @(negedge clk);
            en_t = 1'b1; i_sync = 1'b1; drive_vec(-1);
        end
        @(negedge clk);
        i_sync = 1'b0; en_t = 1'b1;
        @(negedge clk);
        chk("missing_bits", 64'(exp_q.size()), 64'd0);
    endtask

    // Per-cycle compare against the model queue.
    initial begin : monitor
        logic en_s, rst_s, st_s, e, in_block, first_seen;
        int since;
        in_block = 1'b0; first_seen = 1'b0; since = 0;
        forever begin
            @(posedge clk);
            en_s = en_t; rst_s = rst; st_s = start_flag;
            #1;
            if (!rst_s) begin
                chk("reset_outs", 64'({o_valid, o_done, o_bit, o_busy}), 64'd0);
                exp_q.delete();
                in_block = 1'b0;
            end else begin
                if (st_s && en_s) begin
                    since = 0; in_block = 1'b1; first_seen = 1'b0;
                end else if (in_block && en_s) begin
                    since++;
                end
                if (!en_s) chk("gap_quiet", 64'({o_valid, o_done}), 64'd0);
                if (o_valid) begin
                    n_valid++;
                    if (exp_q.size() == 0) begin
                        chk("spurious_valid", 64'(o_valid), 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("bit", 64'(o_bit), 64'(e));
                        chk("done_align", 64'(o_done), 64'(exp_q.size() == 0));
                        chk("busy", 64'(o_busy), 64'(exp_q.size() != 0));
                        if (!first_seen) begin
                            chk("latency", 64'(since), 64'(TB_DEPTH + 1));
                            first_seen = 1'b1;
                        end
                    end
                end else begin
                    chk("done_without_valid", 64'(o_done), 64'd0);
                end
                if (o_done) n_done++;
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin : main
        pat = 64'hDEADBEEF_0123ABCD;
        rst = 1'b0; en_t = 1'b0; i_sync = 1'b0; start_flag = 1'b0;
        i_start_st = '0; drive_vec(-1);
        repeat (3) @(negedge clk);
        rst = 1'b1; en_t = 1'b1;
        @(negedge clk);

        run_block(M_ID,    8'h80,                0,  -1,            1'b0, 0);
        run_block(M_SHIFT, shift_s0(),           0,  -1,            1'b0, 0);
        run_block(M_RAND,  state_t'($urandom),   0,  -1,            1'b0, 0);
        run_block(M_SHIFT, shift_s0(),           30, -1,            1'b0, 0);
        run_block(M_RAND,  state_t'($urandom),   0,  -1,            1'b0, 300 - 2 * TB_DEPTH - 1);
        run_block(M_RAND,  state_t'($urandom),   0,  -1,            1'b0, 0);
        run_block(M_RAND,  state_t'($urandom),   0,  -1,            1'b1, 0);
        run_block(M_RAND,  state_t'($urandom),   25, 20,            1'b0, 0);
        run_block(M_SHIFT, shift_s0(),           30, -1,            1'b0, 0);
        run_block(M_RAND,  state_t'($urandom),   25, TB_DEPTH + 10, 1'b0, 0);
        run_block(M_START, 8'h3C,                0,  -1,            1'b0, 0);
        for (int r = 0; r < 3; r++)
            run_block(M_RAND, state_t'($urandom), 30, -1, 1'b0, 0);

        repeat (5) @(negedge clk);
        chk("valid_total", 64'(n_valid), 64'(exp_valid));
        chk("done_total",  64'(n_done),  64'(exp_done));
        chk("idle_busy",   64'(o_busy),  64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
